booth_mul_seq: RTL and testbench



---
 rtl/booth_pkg.sv | 21 ++
 rtl/booth_radix2_step.sv | 29 ++
 rtl/booth_mul_seq.sv | 109 ++++++++++
 tb/tb_booth_mul_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// FSM state encodings and the counter-width helper.
package booth_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t RUN  = 2'd1;
   localparam state_t DONE = 2'd2;

   // Bits needed to hold values 0..v-1; evaluated at elaboration only.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/booth_radix2_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then an
// arithmetic right shift of the concatenation {A, Q, q_1}.
module booth_radix2_step #(
   parameter int WIDTH = 17
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic             q_1_i,
   input  logic [WIDTH-1:0] m_i,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] q_o,
   output logic             q_1_o
);

   logic [WIDTH-1:0] sum;

   always_comb begin
      sum = a_i;
      case ({q_i[0], q_1_i})
         2'b01:   sum = a_i + m_i;
         2'b10:   sum = a_i - m_i;
         default: sum = a_i;
      endcase
      a_o   = {sum[WIDTH-1], sum[WIDTH-1:1]};
      q_o   = {sum[0], q_i[WIDTH-1:1]};
      q_1_o = q_i[0];
   end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-2 Booth multiplier with valid/ready operand and result
// handshakes; one add/sub-and-shift step per clock, WIDTH+1 steps per product.
module booth_mul_seq
   import booth_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               is_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int unsigned N  = WIDTH + 1;
   localparam int unsigned CW = clog2(WIDTH + 2);

   state_t             state_q, state_d;
   logic [N-1:0]       m_q, m_d;
   logic [N-1:0]       acc_q, acc_d;
   logic [N-1:0]       mq_q, mq_d;
   logic               q1_q, q1_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] product_q, product_d;

   logic [N-1:0]       step_a;
   logic [N-1:0]       step_q;
   logic               step_q1;

   booth_radix2_step #(.WIDTH(N)) u_step (
      .a_i   (acc_q),
      .q_i   (mq_q),
      .q_1_i (q1_q),
      .m_i   (m_q),
      .a_o   (step_a),
      .q_o   (step_q),
      .q_1_o (step_q1)
   );

   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      acc_d     = acc_q;
      mq_d      = mq_q;
      q1_d      = q1_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               // The mode is captured in the extension bit of M and Q.
               m_d     = {is_signed & a[WIDTH-1], a};
               mq_d    = {is_signed & b[WIDTH-1], b};
               acc_d   = '0;
               q1_d    = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = step_a;
            mq_d  = step_q;
            q1_d  = step_q1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH)) begin
               // {A,Q} is 2*WIDTH+2 bits; the top two are pure sign copies.
               product_d = {step_a[WIDTH-2:0], step_q};
               state_d   = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         m_q       <= '0;
         acc_q     <= '0;
         mq_q      <= '0;
         q1_q      <= 1'b0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         acc_q     <= acc_d;
         mq_q      <= mq_d;
         q1_q      <= q1_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == RUN);
   assign out_valid = (state_q == DONE);
   assign product   = product_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq at WIDTH 16, 4 and 32 against a
// plain-arithmetic reference product.
module tb_booth_mul_seq;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic        iv16, ir16, s16, ov16, or16, busy16;
   logic [15:0] a16, b16;
   logic [31:0] p16;
   logic        iv4, ir4, s4, ov4, or4, busy4;
   logic [3:0]  a4, b4;
   logic [7:0]  p4;
   logic        iv32, ir32, s32, ov32, or32, busy32;
   logic [31:0] a32, b32;
   logic [63:0] p32;

   booth_mul_seq #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
      .is_signed(s16), .out_valid(ov16), .out_ready(or16), .product(p16), .busy(busy16));
   booth_mul_seq #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
      .is_signed(s4), .out_valid(ov4), .out_ready(or4), .product(p4), .busy(busy4));
   booth_mul_seq #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
      .is_signed(s32), .out_valid(ov32), .out_ready(or32), .product(p32), .busy(busy32));

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Reference: extend each operand to 64 bits per mode, multiply, keep 2*w bits.
   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input int w, input logic s);
      logic [63:0] mask_w, ua, ub, mask_p;
      mask_w = (64'd1 << w) - 64'd1;
      ua = 64'(a) & mask_w;
      ub = 64'(b) & mask_w;
      if (s && a[w-1]) ua = ua | ~mask_w;
      if (s && b[w-1]) ub = ub | ~mask_w;
      mask_p = (w == 32) ? '1 : (64'd1 << (2 * w)) - 64'd1;
      return (ua * ub) & mask_p;
   endfunction

   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                       output logic [31:0] p, output int lat);
      int n = 0;
      @(negedge clk);
      while (!ir16 && n < 100) begin @(negedge clk); n++; end
      a16 = a; b16 = b; s16 = s; iv16 = 1'b1;
      @(posedge clk); #1;
      iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); s16 = ~s;
      check("run16 flags", 64'({ir16, busy16}), 64'd1);
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!ov16 && lat < 200);
      p = p16;
      @(negedge clk); or16 = 1'b1;
      @(posedge clk); #1; or16 = 1'b0;
   endtask

   task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s,
                      output logic [7:0] p, output int lat);
      int n = 0;
      @(negedge clk);
      while (!ir4 && n < 100) begin @(negedge clk); n++; end
      a4 = a; b4 = b; s4 = s; iv4 = 1'b1;
      @(posedge clk); #1;
      iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); s4 = ~s;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!ov4 && lat < 200);
      p = p4;
      @(negedge clk); or4 = 1'b1;
      @(posedge clk); #1; or4 = 1'b0;
   endtask

   task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [63:0] p, output int lat);
      int n = 0;
      @(negedge clk);
      while (!ir32 && n < 100) begin @(negedge clk); n++; end
      a32 = a; b32 = b; s32 = s; iv32 = 1'b1;
      @(posedge clk); #1;
      iv32 = 1'b0; a32 = $urandom; b32 = $urandom; s32 = ~s;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!ov32 && lat < 200);
      p = p32;
      @(negedge clk); or32 = 1'b1;
      @(posedge clk); #1; or32 = 1'b0;
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        s;
      logic [31:0] exp;
   } vec_t;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt[9];
      logic [31:0] r16;
      logic [7:0]  r4;
      logic [63:0] r32;
      logic [31:0] ra, rb;
      logic        rs;
      logic        spurious;
      int          lat;

      vt[0] = '{16'h0003, 16'hFFFC, 1'b1, 32'hFFFF_FFF4};
      vt[1] = '{16'h8000, 16'h8000, 1'b1, 32'h4000_0000};
      vt[2] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001};
      vt[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001};
      vt[4] = '{16'h0007, 16'h0009, 1'b0, 32'h0000_003F};
      vt[5] = '{16'h0000, 16'hABCD, 1'b1, 32'h0000_0000};
      vt[6] = '{16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000};
      vt[7] = '{16'hFFFF, 16'h0002, 1'b1, 32'hFFFF_FFFE};
      vt[8] = '{16'h8000, 16'hFFFF, 1'b0, 32'h7FFF_8000};

      {iv16, s16, or16, a16, b16} = '0;
      {iv4, s4, or4, a4, b4} = '0;
      {iv32, s32, or32, a32, b32} = '0;
      rst = 1'b1;
      #12;
      check("reset16", 64'({ir16, ov16, busy16, p16}), 64'({3'b100, 32'd0}));
      check("reset4", 64'({ir4, ov4, busy4, p4}), 64'({3'b100, 8'd0}));
      check("reset32", {ir32, ov32, busy32, p32[60:0]}, {3'b100, 61'd0});
      @(negedge clk); rst = 1'b0;

      foreach (vt[i]) begin
         op16(vt[i].a, vt[i].b, vt[i].s, r16, lat);
         check($sformatf("vec%0d product", i), 64'(r16), 64'(vt[i].exp));
         check($sformatf("vec%0d latency", i), 64'(lat), 64'd17);
      end

      // Backpressure, with new operands presented during RUN and DONE.
      @(negedge clk);
      a16 = 16'd5; b16 = 16'd6; s16 = 1'b0; iv16 = 1'b1;
      @(posedge clk); #1;
      a16 = 16'd100; b16 = 16'd100;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!ov16 && lat < 200);
      check("bp latency", 64'(lat), 64'd17);
      repeat (10) begin
         @(posedge clk); #1;
         check("bp hold", 64'({ov16, ir16, p16}), 64'({2'b10, 32'd30}));
      end
      @(negedge clk); iv16 = 1'b0; or16 = 1'b1;
      @(posedge clk); #1; or16 = 1'b0;
      check("bp release", 64'({ov16, ir16}), 64'd1);
      op16(16'd2, 16'd3, 1'b0, r16, lat);
      check("bp next op", 64'(r16), 64'd6);

      // Asynchronous reset in the middle of a run.
      @(negedge clk);
      a16 = 16'd1234; b16 = 16'd567; s16 = 1'b0; iv16 = 1'b1;
      @(posedge clk); #1; iv16 = 1'b0;
      repeat (8) @(posedge clk);
      #2 rst = 1'b1;
      #1 check("midrun reset", 64'({ir16, ov16, busy16, p16}), 64'({3'b100, 32'd0}));
      @(negedge clk); rst = 1'b0;
      spurious = 1'b0;
      repeat (25) begin @(posedge clk); #1; if (ov16) spurious = 1'b1; end
      check("no spurious out_valid", 64'(spurious), 64'd0);
      op16(16'd7, 16'd9, 1'b0, r16, lat);
      check("post-reset 7x9", 64'(r16), 64'd63);

      for (int i = 0; i < 200; i++) begin
         ra = $urandom; rb = $urandom; rs = 1'($urandom);
         op16(ra[15:0], rb[15:0], rs, r16, lat);
         check($sformatf("rand16 %0h*%0h s=%0d", ra[15:0], rb[15:0], rs),
               64'(r16), ref_mul(ra, rb, 16, rs));
      end

      for (int m = 0; m < 2; m++) begin
         for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
               op4(4'(x), 4'(y), 1'(m), r4, lat);
               check($sformatf("w4 %0d*%0d s=%0d", x, y, m), 64'(r4),
                     ref_mul(32'(x), 32'(y), 4, 1'(m)));
               check($sformatf("w4 latency %0d*%0d", x, y), 64'(lat), 64'd5);
            end
         end
      end

      op32(32'h8000_0000, 32'h8000_0000, 1'b1, r32, lat);
      check("w32 minneg^2", r32, 64'h4000_0000_0000_0000);
      check("w32 latency", 64'(lat), 64'd33);
      op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r32, lat);
      check("w32 max unsigned^2", r32, 64'hFFFF_FFFE_0000_0001);
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom; rb = $urandom; rs = 1'($urandom);
         op32(ra, rb, rs, r32, lat);
         check($sformatf("rand32 %0h*%0h s=%0d", ra, rb, rs), r32, ref_mul(ra, rb, 32, rs));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
